// File: rtl/rgbw_pwm_engine.sv
// rgbw_pwm_engine
//   Four-channel (R,G,B,W) PWM output stage. It double-buffers 8-bit duty
//   values so that a new duty only takes effect at a PWM period boundary.
//   The counter advances on the clk_half enable tick. All logic runs on clk.
//
//   Optional feature macro: RGBW_PWM_PHASE_STAGGER_EN
//     defined   : channel k compares against cnt + k*2**(WIDTH-2). This
//                 spreads the four rising edges a quarter period apart.
//     undefined : all channels compare against cnt and rise together.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   clk_half      one-clk enable tick that advances the counter
//   en            run request; 0 stops the engine at the end of the period
//   load          strobe; captures duty0..duty3 into the shadow registers
//   duty0..duty3  red/green/blue/white duty (high ticks per period)
//   load_ack      one-clk pulse when shadow is copied to active
//   period_start  one-clk pulse on each period start while running
//   busy          high in RUN or DRAIN
//   d0..d3        registered PWM outputs (red, green, blue, white)
module rgbw_pwm_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_half,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] duty0,
  input  logic [WIDTH-1:0] duty1,
  input  logic [WIDTH-1:0] duty2,
  input  logic [WIDTH-1:0] duty3,
  output logic             load_ack,
  output logic             period_start,
  output logic             busy,
  output logic             d0,
  output logic             d1,
  output logic             d2,
  output logic             d3
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] shadow [4];
  logic [WIDTH-1:0] active [4];
  logic [WIDTH-1:0] duty_in [4];
  logic [WIDTH-1:0] ccnt [4];
  logic             pending;
  logic [3:0]       dq;

  logic at_end;
  logic run_wrap;
  logic start;
  logic apply;

  assign duty_in[0] = duty0;
  assign duty_in[1] = duty1;
  assign duty_in[2] = duty2;
  assign duty_in[3] = duty3;

  // A wrap with en high starts a new running period. DRAIN with en
  // re-raised on the wrap cycle is treated the same as RUN.
  assign at_end   = clk_half && (cnt == CNT_MAX);
  assign run_wrap = at_end && en && ((state == S_RUN) || (state == S_DRAIN));
  assign start    = (state == S_IDLE) && en;
  assign apply    = (run_wrap || start) && pending;

  assign busy = (state != S_IDLE);

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
`ifdef RGBW_PWM_PHASE_STAGGER_EN
      ccnt[k] = cnt + WIDTH'(k << (WIDTH - 2));
`else
      ccnt[k] = cnt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      pending      <= 1'b0;
      load_ack     <= 1'b0;
      period_start <= 1'b0;
      dq           <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      load_ack     <= 1'b0;
      period_start <= 1'b0;

      case (state)
        S_IDLE: begin
          if (en) state <= S_RUN;
        end
        S_RUN: begin
          if (!en) state <= at_end ? S_IDLE : S_DRAIN;
        end
        S_DRAIN: begin
          if (en)          state <= S_RUN;
          else if (at_end) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (state == S_IDLE)  cnt <= '0;
      else if (clk_half)    cnt <= cnt + 1'b1;

      if (run_wrap || start) period_start <= 1'b1;

      if (apply) begin
        active   <= shadow;
        pending  <= 1'b0;
        load_ack <= 1'b1;
      end

      // A load on the apply cycle must survive. It comes after the apply
      // so that it overrides the pending clear.
      if (load) begin
        shadow  <= duty_in;
        pending <= 1'b1;
      end

      for (int unsigned k = 0; k < 4; k++) begin
        dq[k] <= (state != S_IDLE) && (ccnt[k] < active[k]);
      end
    end
  end

  assign d0 = dq[0];
  assign d1 = dq[1];
  assign d2 = dq[2];
  assign d3 = dq[3];

endmodule
